// File: rtl/hazard_pkg.sv
// Shared constants for the fetch/decode hazard controller: opcodes, FSM state
// encoding and the "instruction reads rt" classifier.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LSTALL  = 3'd1,
    BRWAIT  = 3'd2,
    BRFLUSH = 3'd3,
    JFLUSH  = 3'd4
  } state_t;

  // lw writes rt rather than reading it, so only these opcodes source rt
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones,
// cleared by synchronous reset.
module hazard_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Fetch/decode hazard controller: load-use bubbles, branch-resolve hold and
// jump/taken-branch squash. Optional stall statistics under HAZARD_STATS_EN.
module branch_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int BR_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             br_resolve,
  input  logic             br_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             flush_f_n,
  output logic             flush_d_n,
`ifdef HAZARD_STATS_EN
  output logic [CNT_W-1:0] stall_cycles,
`endif
  output logic             br_timeout
);

  // Qualifiers: id_valid qualifies id_instr and is only sampled in IDLE;
  // br_resolve qualifies br_taken and is only sampled in BRWAIT. No backpressure.

  localparam int BR_CW = (BR_LAT > 1) ? $clog2(BR_LAT) : 1;
  localparam logic [BR_CW-1:0] CNT_INIT = BR_CW'(BR_LAT - 1);

  state_t           state, state_nxt;
  logic [BR_CW-1:0] cnt, cnt_nxt;
  logic             timeout_set;

  logic [5:0] op;
  logic [4:0] rs, rt;
  logic       load_use;
  logic       unused_instr_bits;

  assign op = id_instr[31:26];
  assign rs = id_instr[25:21];
  assign rt = id_instr[20:16];
  assign unused_instr_bits = ^id_instr[15:0];

  assign load_use = id_valid && ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == rs) || ((ex_rt == rt) && uses_rt(op)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      br_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (timeout_set) br_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    timeout_set = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    flush_f_n   = 1'b1;
    flush_d_n   = 1'b1;
    case (state)
      IDLE: begin
        if (id_valid) begin
          if (load_use) begin
            state_nxt = LSTALL;
          end else if ((op == OP_BEQ) || (op == OP_BNE)) begin
            state_nxt = BRWAIT;
            cnt_nxt   = CNT_INIT;
          end else if (op == OP_J) begin
            state_nxt = JFLUSH;
          end
        end
      end
      LSTALL: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        flush_d_n   = 1'b0;
        state_nxt   = IDLE;
      end
      BRWAIT: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        flush_d_n   = 1'b0;
        // a resolve arriving on the last countdown cycle still beats the timeout
        if (br_resolve) begin
          state_nxt = br_taken ? BRFLUSH : IDLE;
        end else if (cnt == '0) begin
          state_nxt   = IDLE;
          timeout_set = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      BRFLUSH, JFLUSH: begin
        flush_f_n = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef HAZARD_STATS_EN
  hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~pc_write),
    .count (stall_cycles)
  );
`else
  logic [CNT_W-1:0] unused_stats;
  assign unused_stats = '0;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: driver pushes hand-computed output
// vectors {pc_write, if_id_write, flush_f_n, flush_d_n, br_timeout}; monitor pops.
module tb_branch_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        br_resolve;
  logic        br_taken;
  logic        pc_write, if_id_write, flush_f_n, flush_d_n, br_timeout;
`ifdef HAZARD_STATS_EN
  logic [1:0]  stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  // Output vectors
  localparam logic [4:0] E_IDLE  = 5'b11110;
  localparam logic [4:0] E_STALL = 5'b00100;
  localparam logic [4:0] E_FLUSH = 5'b11010;
  localparam logic [4:0] E_TO    = 5'b00001;

  // Instructions
  localparam logic [31:0] I_NOP = 32'd0;
  localparam logic [31:0] I_ADD = {6'b000000, 5'd5, 5'd6, 5'd7, 11'h020};
  localparam logic [31:0] I_LW  = {6'b100011, 5'd1, 5'd5, 16'h0004};
  localparam logic [31:0] I_SW  = {6'b101011, 5'd1, 5'd5, 16'h0008};
  localparam logic [31:0] I_BEQ = {6'b000100, 5'd1, 5'd2, 16'h0010};
  localparam logic [31:0] I_J   = {6'b000010, 26'h0000040};

  branch_hazard_ctrl #(.BR_LAT(2), .CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .br_resolve   (br_resolve),
    .br_taken     (br_taken),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .flush_f_n    (flush_f_n),
    .flush_d_n    (flush_d_n),
`ifdef HAZARD_STATS_EN
    .stall_cycles (stall_cycles),
`endif
    .br_timeout   (br_timeout)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    rst         = 1'b1;
    id_instr    = '0;
    id_valid    = 1'b0;
    ex_mem_read = 1'b0;
    ex_rt       = '0;
    br_resolve  = 1'b0;
    br_taken    = 1'b0;
  end

  // Driver: after each edge, queue the outputs expected for this cycle,
  // then apply the inputs that take effect at the next edge.
  task automatic step(input logic r, input logic [31:0] instr, input logic v,
                      input logic mr, input logic [4:0] ert,
                      input logic res, input logic tk, input logic [4:0] exp);
    @(posedge clk);
    #1;
    exp_q.push_back(exp);
    rst         = r;
    id_instr    = instr;
    id_valid    = v;
    ex_mem_read = mr;
    ex_rt       = ert;
    br_resolve  = res;
    br_taken    = tk;
  endtask

  task automatic idle(input logic [4:0] exp);
    step(1'b0, I_NOP, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, exp);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [4:0] e;
      logic [4:0] act;
      e   = exp_q.pop_front();
      act = {pc_write, if_id_write, flush_f_n, flush_d_n, br_timeout};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got %b expected %b", $time, act, e);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Reset, then plain add
    step(1'b1, I_NOP, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE);
    step(1'b1, I_NOP, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE);
    step(1'b0, I_ADD, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE);
    // Load-use on rs
    step(1'b0, I_ADD, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, E_IDLE);
    idle(E_STALL);
    idle(E_IDLE);
    // ex_rt == 0 never hazards
    step(1'b0, I_ADD, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, E_IDLE);
    idle(E_IDLE);
    // lw matching only on rt: no hazard; sw matching on rt: hazard
    step(1'b0, I_LW, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, E_IDLE);
    step(1'b0, I_SW, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, E_IDLE);
    idle(E_STALL);
    // beq taken
    step(1'b0, I_BEQ, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE);
    step(1'b0, I_NOP, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, E_STALL);
    idle(E_FLUSH);
    idle(E_IDLE);
    // beq not taken
    step(1'b0, I_BEQ, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE);
    step(1'b0, I_NOP, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, E_STALL);
    // resolve in IDLE ignored
    step(1'b0, I_NOP, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, E_IDLE);
    idle(E_IDLE);
    // Timeout; a jump in decode while waiting is ignored
    step(1'b0, I_BEQ, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE);
    step(1'b0, I_J,   1'b1, 1'b0, 5'd0, 1'b0, 1'b0, E_STALL);
    idle(E_STALL);
    idle(E_IDLE | E_TO);
    idle(E_IDLE | E_TO);
    // Resolve on the last countdown cycle beats timeout
    step(1'b0, I_BEQ, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE | E_TO);
    idle(E_STALL | E_TO);
    step(1'b0, I_NOP, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, E_STALL | E_TO);
    idle(E_FLUSH | E_TO);
    idle(E_IDLE | E_TO);
    // Jump
    step(1'b0, I_J, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE | E_TO);
    idle(E_FLUSH | E_TO);
    idle(E_IDLE | E_TO);
    // id_valid low masks a hazard
    step(1'b0, I_ADD, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, E_IDLE | E_TO);
    idle(E_IDLE | E_TO);
    // Reset during BRWAIT clears state and sticky timeout
    step(1'b0, I_BEQ, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE | E_TO);
    step(1'b1, I_NOP, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_STALL | E_TO);
    idle(E_IDLE);
    idle(E_IDLE);
    // Five load-use stalls back to back
    for (int i = 0; i < 5; i++) begin
      step(1'b0, I_ADD, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, E_IDLE);
      idle(E_STALL);
    end
    idle(E_IDLE);
    @(negedge clk);
    #1;
`ifdef HAZARD_STATS_EN
    checks++;
    if (stall_cycles !== 2'd3) begin
      errors++;
      $display("FAIL stall_cycles: got %0d expected 3", stall_cycles);
    end
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
